prog_sequencer: RTL
===================

Name: prog_sequencer

Overview:
Run-control FSM that sequences the instruction-fetch program counter across the three test-bench programs. It detects Start edges, selects the program base address, and drives load/enable commands to the PC register. It also resolves conditional relative branches against the active program's base, halts on the decoder's done instruction, and reports Done plus a per-program cycle count back to the bench.

Parameters:
A, 10, instruction-memory address width (PC width)
NUM_PROGS, 3, number of programs in the series (1..3)
CW, 16, width of run-cycle counter

Ports:
Clk  in  1  clock; all state changes on posedge
Reset  in  1  synchronous, active-high; Reset Reset, synchronous, active-high; clock Clk
Start  in  1  bench request; rising edge arms next program, falling edge launches it
HaltInstr  in  1  decoder: current instruction is program-done
BranchRelEn  in  1  decoder: current instruction is conditional relative branch
AluFlag  in  1  ALU branch condition met
Target  in  8  branch offset from program base (unsigned)
PcEn  out  1  PC may increment this cycle (combinational)
PcLoad  out  1  PC loads PcLoadVal this cycle (combinational; overrides PcEn)
PcLoadVal  out  A  value to load (combinational)
ProgId  out  2  index of current/last program, 0 = none yet (registered)
Running  out  1  high in RUN (registered state decode)
Done  out  1  high in DONE (registered state decode)
CycleCount  out  CW  cycles spent in RUN for current/last program (registered)

Behaviour:
- Reset: state IDLE, start_r=0, ProgId=0, CycleCount=0, Running=0, Done=0; PcEn=0, PcLoad=0, PcLoadVal=0. Reset mid-run aborts immediately, with no Done pulse.
- start_r <= Start every non-reset cycle, in all states. rise = Start & ~start_r; fall = ~Start & start_r.
- States: IDLE, ARMED, RUN, DONE.
- IDLE/DONE: on rise with ProgId < NUM_PROGS -> ARMED, ProgId <= ProgId+1. A rise with ProgId == NUM_PROGS is ignored and the state stays put.
- ARMED: on fall -> RUN. Same cycle: PcLoad=1, PcLoadVal=BASE[ProgId], CycleCount <= 0.
- RUN: PcEn=1 by default. CycleCount increments each cycle and saturates at all-ones.
  - Taken branch (BranchRelEn & AluFlag): PcLoad=1, PcLoadVal = BASE[ProgId] + zero-extended Target, modulo 2^A.
  - HaltInstr: -> DONE, PcEn=0, PcLoad=0; CycleCount does not increment that cycle.
  - HaltInstr together with a taken branch: halt wins, no load.
  - Start edges are ignored in RUN.
- Outputs PcEn=0 and PcLoad=0 in IDLE, ARMED and DONE (PC holds).
- PcLoadVal=0 whenever PcLoad=0.
- Latency: ProgId, Running and Done update one cycle after the triggering edge/instruction. PC commands are same-cycle.
- Rise and fall cannot occur in the same cycle. A Start pulse of any width >= 1 cycle is valid.

Decomposition:
- Package prog_seq_pkg:
  - state enum (IDLE, ARMED, RUN, DONE)
  - BASE address constant array {0, 200, 500}, indexed by ProgId 1..3
  - NUM_PROGS default
- One sub-module, start_edge_det: start_r register plus rise/fall outputs.

Test Plan:
- Reset, then Start 0->1->0 -> ProgId=1; on the fall cycle PcLoad=1, PcLoadVal=0; next cycle Running=1, PcEn=1.
- Program 2 running, BranchRelEn=1, AluFlag=1, Target=37 -> PcLoad=1, PcLoadVal=237. Same inputs with AluFlag=0 -> PcLoad=0, PcEn=1.
- Program 3 launch -> PcLoadVal=500. Target=255 -> PcLoadVal=755. Fourth Start pulse after DONE -> ignored, ProgId stays 3, state DONE.
- Run 10 cycles, then HaltInstr=1 together with a taken branch -> PcLoad=0, PcEn=0; next cycle Done=1, Running=0, CycleCount=10.
- Start toggled during RUN -> no state change, PC commands unaffected.
- Reset asserted while in RUN -> next cycle state IDLE, ProgId=0, CycleCount=0, Done=0, PcEn=0.

Source files
------------

// File: rtl/prog_seq_pkg.sv
// Shared types and constants for the program run-control sequencer.
package prog_seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } state_e;

    localparam int NUM_PROGS_DEF = 3;

    // Program base addresses, indexed by ProgId 1..3 (index 0 = no program yet).
    function automatic int unsigned base_addr(input logic [1:0] prog_id);
        case (prog_id)
            2'd2:    base_addr = 200;
            2'd3:    base_addr = 500;
            default: base_addr = 0;
        endcase
    endfunction

endpackage

// File: rtl/prog_sequencer_start_edge.sv
// Registers the bench Start line and reports its rising and falling edges.
module start_edge_det (
    input  logic Clk,
    input  logic Reset,
    input  logic Start,
    output logic rise,
    output logic fall
);

    logic start_r_q;
    logic start_r_d;

    always_comb start_r_d = Start;

    always_ff @(posedge Clk) begin
        if (Reset) start_r_q <= 1'b0;
        else       start_r_q <= start_r_d;
    end

    assign rise = Start & ~start_r_q;
    assign fall = ~Start & start_r_q;

endmodule

// File: rtl/prog_sequencer.sv
// Run-control FSM: arms/launches successive programs, drives PC load/enable,
// resolves base-relative branches and counts cycles spent running.
module prog_sequencer
    import prog_seq_pkg::*;
#(
    parameter int A         = 10,
    parameter int NUM_PROGS = NUM_PROGS_DEF,
    parameter int CW        = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          HaltInstr,
    input  logic          BranchRelEn,
    input  logic          AluFlag,
    input  logic [7:0]    Target,
    output logic          PcEn,
    output logic          PcLoad,
    output logic [A-1:0]  PcLoadVal,
    output logic [1:0]    ProgId,
    output logic          Running,
    output logic          Done,
    output logic [CW-1:0] CycleCount
);

    localparam logic [1:0] LAST_ID = 2'(NUM_PROGS);

    state_e          state_q, state_d;
    logic [1:0]      prog_id_q, prog_id_d;
    logic [CW-1:0]   cycle_count_q, cycle_count_d;
    logic            rise, fall;
    logic [A-1:0]    base;

    start_edge_det u_edge (
        .Clk   (Clk),
        .Reset (Reset),
        .Start (Start),
        .rise  (rise),
        .fall  (fall)
    );

    assign base = A'(base_addr(prog_id_q));

    always_comb begin
        state_d       = state_q;
        prog_id_d     = prog_id_q;
        cycle_count_d = cycle_count_q;
        PcEn          = 1'b0;
        PcLoad        = 1'b0;
        PcLoadVal     = '0;
        // PC commands are held off while reset is asserted, even mid-run.
        if (!Reset) begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (rise && prog_id_q < LAST_ID) begin
                        state_d   = S_ARMED;
                        prog_id_d = prog_id_q + 2'd1;
                    end
                end
                S_ARMED: begin
                    if (fall) begin
                        state_d       = S_RUN;
                        PcLoad        = 1'b1;
                        PcLoadVal     = base;
                        cycle_count_d = '0;
                    end
                end
                S_RUN: begin
                    if (HaltInstr) begin
                        state_d = S_DONE;
                    end else begin
                        PcEn = 1'b1;
                        if (cycle_count_q != '1) cycle_count_d = cycle_count_q + CW'(1);
                        if (BranchRelEn && AluFlag) begin
                            PcLoad    = 1'b1;
                            PcLoadVal = base + A'(Target);
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q       <= S_IDLE;
            prog_id_q     <= '0;
            cycle_count_q <= '0;
        end else begin
            state_q       <= state_d;
            prog_id_q     <= prog_id_d;
            cycle_count_q <= cycle_count_d;
        end
    end

    assign ProgId     = prog_id_q;
    assign Running    = (state_q == S_RUN);
    assign Done       = (state_q == S_DONE);
    assign CycleCount = cycle_count_q;

endmodule
